// File: rtl/perf_pkg.sv
// Shared types and counter index map for the performance-monitor unit.
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_e;

    localparam int unsigned IDX_CYC = 0;
    localparam int unsigned IDX_RET = 1;
    localparam int unsigned IDX_EV0 = 2;

    // Total counters for a given number of event channels (cycles + retired + channels).
    function automatic int unsigned numCounters(input int unsigned numCh);
        return numCh + IDX_EV0;
    endfunction

endpackage

// File: rtl/perf_counter_slice.sv
// One event counter with sticky overflow; saturates or wraps at all-ones.
module perf_counter_slice
    import perf_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter bit          SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (&cnt) begin
                cnt <= SATURATE ? cnt : '0;
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/perf_counter_unit.sv
// Performance monitor: cycle, retired and event-channel counters gated by a run/halt FSM,
// with a registered one-cycle-latency read port.
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = 32,
    parameter bit          SATURATE = 1'b1,
    localparam int unsigned NUM_CNT = NUM_CH + 2,
    localparam int unsigned IDX_W   = $clog2(NUM_CNT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic               halt,
    input  logic               retire,
    input  logic [NUM_CH-1:0]  ev,
    input  logic               rd_req,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_valid,
    output logic [CNT_W-1:0]   rd_data,
    output logic [NUM_CNT-1:0] ovf,
    output logic               frozen
);

    state_e             state;
    logic               counting;
    logic [NUM_CNT-1:0] incVec;
    logic [CNT_W-1:0]   cntArr [NUM_CNT];
    logic [CNT_W-1:0]   rdMux;

    assign counting = (state == RUN);

    // Bit order follows the read index map: cycles, retired, then channels.
    assign incVec = {ev, retire, 1'b1} & {NUM_CNT{counting}};

    for (genvar i = 0; i < NUM_CNT; i++) begin : gSlice
        perf_counter_slice #(
            .CNT_W   (CNT_W),
            .SATURATE(SATURATE)
        ) uSlice (
            .clk(clk),
            .rst(rst),
            .inc(incVec[i]),
            .clr(clr),
            .cnt(cntArr[i]),
            .ovf(ovf[i])
        );
    end

    // The halt cycle itself is still in RUN, so its increments land before freezing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            frozen <= 1'b0;
        end else if (clr) begin
            state  <= IDLE;
            frozen <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (halt) begin
                        state  <= HALTED;
                        frozen <= 1'b1;
                    end else if (!en) begin
                        state <= IDLE;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state  <= IDLE;
                    frozen <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rdMux = '0;
        if (32'(rd_idx) < NUM_CNT) begin
            rdMux = cntArr[rd_idx];
        end
    end

    // Captures pre-update values, so a read in a clear cycle returns the old count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= rdMux;
            end
        end
    end

endmodule
